// File: rtl/prv_trap_if.sv
// rtl/prv_trap_if.sv - pipeline/CSR interface between hazard unit and trap responder
interface prv_trap_if #(parameter int XLEN = 32);
    logic            fault_insn;
    logic            mal_insn;
    logic            illegal_insn;
    logic            breakpoint;
    logic            env;
    logic            mal_l;
    logic            mal_s;
    logic            fault_l;
    logic            fault_s;
    logic            wb_enable;
    logic            ret;
    logic            wfi;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] badaddr;
    logic [2:0]      ints_pending;
    logic [2:0]      ints_enabled;
    logic [XLEN-1:0] mtvec;
    logic            csr_wen;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            intr;
    logic            insert_pc;
    logic [XLEN-1:0] priv_pc;
    logic            wfi_sleep;
    logic            mie_out;

    modport master (
        output fault_insn, mal_insn, illegal_insn, breakpoint, env,
               mal_l, mal_s, fault_l, fault_s, wb_enable, ret, wfi,
               epc, badaddr, ints_pending, ints_enabled, mtvec,
               csr_wen, csr_addr, csr_wdata,
        input  csr_rdata, intr, insert_pc, priv_pc, wfi_sleep, mie_out
    );

    modport slave (
        input  fault_insn, mal_insn, illegal_insn, breakpoint, env,
               mal_l, mal_s, fault_l, fault_s, wb_enable, ret, wfi,
               epc, badaddr, ints_pending, ints_enabled, mtvec,
               csr_wen, csr_addr, csr_wdata,
        output csr_rdata, intr, insert_pc, priv_pc, wfi_sleep, mie_out
    );
endinterface

// File: rtl/prv_trap_responder.sv
// rtl/prv_trap_responder.sv - trap/return commit, M-mode trap CSRs and PC redirect
// Optional VECTORED_MTVEC_EN: interrupts vector to base + 4*cause when mtvec mode is 01.
module prv_trap_responder #(
  parameter int XLEN = 32
) (
  input logic   CLK,
  input logic   RST,
  prv_trap_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REDIRECT, SLEEP} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] mepc, mcause, mtval, priv_pc;
  logic            mie, mpie, insert_pc, wfi_sleep;

  logic            any_exc, intr, exc_has_tval;
  logic            take_exc, take_int, take_ret;
  logic [2:0]      int_vec;
  logic [3:0]      exc_cause, int_cause;
  logic [XLEN-1:0] trap_base, int_target;
  logic            unused_bits;

  assign any_exc = bus.fault_insn | bus.mal_insn | bus.illegal_insn | bus.breakpoint |
                   bus.env | bus.mal_l | bus.mal_s | bus.fault_l | bus.fault_s;
  assign int_vec = bus.ints_pending & bus.ints_enabled;
  assign intr    = (state == IDLE) & mie & (|int_vec) & ~any_exc;

  // Once the no-address exceptions are ruled out, every remaining winner reports badaddr.
  assign exc_has_tval = bus.fault_insn | bus.mal_insn |
                        ~(bus.illegal_insn | bus.breakpoint | bus.env);

  always_comb begin
    exc_cause = 4'd0;
    if      (bus.fault_insn)   exc_cause = 4'd1;
    else if (bus.mal_insn)     exc_cause = 4'd0;
    else if (bus.illegal_insn) exc_cause = 4'd2;
    else if (bus.breakpoint)   exc_cause = 4'd3;
    else if (bus.env)          exc_cause = 4'd11;
    else if (bus.mal_l)        exc_cause = 4'd4;
    else if (bus.mal_s)        exc_cause = 4'd6;
    else if (bus.fault_l)      exc_cause = 4'd5;
    else if (bus.fault_s)      exc_cause = 4'd7;
  end

  always_comb begin
    int_cause = 4'd7;
    if      (int_vec[2]) int_cause = 4'd11;
    else if (int_vec[0]) int_cause = 4'd3;
  end

  assign trap_base   = {bus.mtvec[XLEN-1:2], 2'b00};
  assign unused_bits = ^{bus.epc[0], bus.mtvec[1:0]};

`ifdef VECTORED_MTVEC_EN
  assign int_target = (bus.mtvec[1:0] == 2'b01)
                    ? trap_base + {{(XLEN-6){1'b0}}, int_cause, 2'b00}
                    : trap_base;
`else
  assign int_target = trap_base;
`endif

  always_comb begin
    state_next = state;
    take_exc   = 1'b0;
    take_int   = 1'b0;
    take_ret   = 1'b0;
    case (state)
      IDLE: begin
        if (any_exc) begin
          take_exc   = 1'b1;
          state_next = REDIRECT;
        end else if (intr && bus.wb_enable) begin
          take_int   = 1'b1;
          state_next = REDIRECT;
        end else if (bus.ret) begin
          take_ret   = 1'b1;
          state_next = REDIRECT;
        end else if (bus.wfi) begin
          state_next = SLEEP;
        end
      end
      REDIRECT: state_next = IDLE;
      SLEEP:    if (|int_vec) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      mepc      <= '0;
      mcause    <= '0;
      mtval     <= '0;
      mie       <= 1'b0;
      mpie      <= 1'b0;
      insert_pc <= 1'b0;
      priv_pc   <= '0;
      wfi_sleep <= 1'b0;
    end else begin
      state     <= state_next;
      insert_pc <= take_exc | take_int | take_ret;
      wfi_sleep <= (state_next == SLEEP);
      if (bus.csr_wen) begin
        case (bus.csr_addr)
          12'h300: begin
            mie  <= bus.csr_wdata[3];
            mpie <= bus.csr_wdata[7];
          end
          12'h341: mepc   <= {bus.csr_wdata[XLEN-1:1], 1'b0};
          12'h342: mcause <= bus.csr_wdata;
          12'h343: mtval  <= bus.csr_wdata;
          default: ;
        endcase
      end
      // Commits come after the CSR write so they win on the same register.
      if (take_exc || take_int) begin
        mepc    <= {bus.epc[XLEN-1:1], 1'b0};
        mcause  <= {take_int, {(XLEN-5){1'b0}}, take_int ? int_cause : exc_cause};
        mtval   <= (take_exc && exc_has_tval) ? bus.badaddr : '0;
        mpie    <= mie;
        mie     <= 1'b0;
        priv_pc <= take_int ? int_target : trap_base;
      end else if (take_ret) begin
        mie     <= mpie;
        mpie    <= 1'b1;
        priv_pc <= mepc;
      end
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};
      12'h341: bus.csr_rdata = mepc;
      12'h342: bus.csr_rdata = mcause;
      12'h343: bus.csr_rdata = mtval;
      default: bus.csr_rdata = '0;
    endcase
  end

  assign bus.intr      = intr;
  assign bus.insert_pc = insert_pc;
  assign bus.priv_pc   = priv_pc;
  assign bus.wfi_sleep = wfi_sleep;
  assign bus.mie_out   = mie;

endmodule

// File: tb/tb_prv_trap_responder.sv
// tb/tb_prv_trap_responder.sv - directed self-checking bench for prv_trap_responder
module tb_prv_trap_responder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  prv_trap_if #(.XLEN(32)) bus ();

  prv_trap_responder #(.XLEN(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    bus.csr_addr = addr;
    #1;
    data = bus.csr_rdata;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_wen   = 1'b1;
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    tick();
    bus.csr_wen   = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    bus.fault_insn = 0; bus.mal_insn = 0; bus.illegal_insn = 0; bus.breakpoint = 0;
    bus.env = 0; bus.mal_l = 0; bus.mal_s = 0; bus.fault_l = 0; bus.fault_s = 0;
    bus.wb_enable = 0; bus.ret = 0; bus.wfi = 0;
    bus.epc = '0; bus.badaddr = '0; bus.ints_pending = '0; bus.ints_enabled = '0;
    bus.mtvec = '0; bus.csr_wen = 0; bus.csr_addr = '0; bus.csr_wdata = '0;

    tick(); tick();
    RST = 1'b0;
    check("rst_insert_pc", {31'd0, bus.insert_pc}, 32'd0);
    check("rst_priv_pc",   bus.priv_pc, 32'd0);
    check("rst_wfi_sleep", {31'd0, bus.wfi_sleep}, 32'd0);
    check("rst_mie",       {31'd0, bus.mie_out}, 32'd0);
    rd(12'h300, v); check("rst_mstatus", v, 32'h0000_1800);
    rd(12'h342, v); check("rst_mcause", v, 32'd0);

    csr_write(12'h300, 32'h0000_0008);
    check("mie_set", {31'd0, bus.mie_out}, 32'd1);

    // illegal instruction trap
    bus.mtvec = 32'h8000_0100; bus.illegal_insn = 1; bus.epc = 32'h2004;
    tick();
    bus.illegal_insn = 0;
    check("t1_insert_pc", {31'd0, bus.insert_pc}, 32'd1);
    check("t1_priv_pc",   bus.priv_pc, 32'h8000_0100);
    rd(12'h342, v); check("t1_mcause", v, 32'd2);
    rd(12'h341, v); check("t1_mepc", v, 32'h2004);
    rd(12'h343, v); check("t1_mtval", v, 32'd0);
    rd(12'h300, v); check("t1_mstatus", v, 32'h0000_1880);
    tick();
    check("t1_insert_pc_drop", {31'd0, bus.insert_pc}, 32'd0);

    // return, with ret held into the redirect cycle
    bus.ret = 1;
    tick();
    check("t4_insert_pc", {31'd0, bus.insert_pc}, 32'd1);
    check("t4_priv_pc",   bus.priv_pc, 32'h2004);
    rd(12'h300, v); check("t4_mstatus", v, 32'h0000_1888);
    tick();
    bus.ret = 0;
    check("t4_ret_in_redirect", {31'd0, bus.insert_pc}, 32'd0);

    // priority: mal_insn beats fault_l; odd epc has bit 0 cleared
    bus.fault_l = 1; bus.mal_insn = 1; bus.badaddr = 32'h3003; bus.epc = 32'h3001;
    tick();
    bus.fault_l = 0; bus.mal_insn = 0;
    rd(12'h342, v); check("t2_mcause", v, 32'd0);
    rd(12'h343, v); check("t2_mtval", v, 32'h3003);
    rd(12'h341, v); check("t2_mepc", v, 32'h3000);
    tick();

    // interrupt held off by wb_enable, then a single commit
    csr_write(12'h300, 32'h0000_0008);
    bus.mtvec = 32'h1001; bus.ints_enabled = 3'b111; bus.ints_pending = 3'b011;
    bus.epc = 32'h5000;
    #1;
    check("t3_intr_early", {31'd0, bus.intr}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_intr_held", {30'd0, bus.intr, bus.insert_pc}, 32'd2);
    end
    bus.wb_enable = 1;
    tick();
    bus.wb_enable = 0;
    check("t3_insert_pc", {31'd0, bus.insert_pc}, 32'd1);
    rd(12'h342, v); check("t3_mcause", v, 32'h8000_0003);
    rd(12'h341, v); check("t3_mepc", v, 32'h5000);
    rd(12'h343, v); check("t3_mtval", v, 32'd0);
`ifdef VECTORED_MTVEC_EN
    check("t3_priv_pc", bus.priv_pc, 32'h100C);
`else
    check("t3_priv_pc", bus.priv_pc, 32'h1000);
`endif
    check("t3_intr_redirect", {31'd0, bus.intr}, 32'd0);
    bus.ints_pending = 3'b000;
    tick();
    check("t3_single_commit", {31'd0, bus.insert_pc}, 32'd0);

    // wfi sleep and wake on mtip with MIE clear
    bus.ints_enabled = 3'b010;
    bus.wfi = 1;
    tick();
    bus.wfi = 0;
    check("t5_sleep", {31'd0, bus.wfi_sleep}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("t5_still_sleep", {31'd0, bus.wfi_sleep}, 32'd1);
    bus.ints_pending = 3'b010;
    tick();
    check("t5_wake", {31'd0, bus.wfi_sleep}, 32'd0);
    check("t5_no_trap", {31'd0, bus.insert_pc}, 32'd0);
    bus.ints_pending = 3'b000;
    tick();
    check("t5_no_trap_late", {31'd0, bus.insert_pc}, 32'd0);

    // mstatus write masking
    csr_write(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, v); check("t6_mstatus_mask", v, 32'h0000_1888);

    // breakpoint then reset during redirect
    bus.mtvec = 32'h8000_0100; bus.breakpoint = 1; bus.epc = 32'h4000;
    tick();
    bus.breakpoint = 0;
    check("t6_bp_insert_pc", {31'd0, bus.insert_pc}, 32'd1);
    rd(12'h342, v); check("t6_bp_mcause", v, 32'd3);
    RST = 1;
    tick();
    RST = 0;
    check("t6_rst_insert_pc", {31'd0, bus.insert_pc}, 32'd0);
    check("t6_rst_priv_pc",   bus.priv_pc, 32'd0);
    check("t6_rst_mie",       {31'd0, bus.mie_out}, 32'd0);
    rd(12'h341, v); check("t6_rst_mepc", v, 32'd0);
    rd(12'h342, v); check("t6_rst_mcause", v, 32'd0);
    tick();
    check("t6_rst_idle", {31'd0, bus.insert_pc}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prv_trap_responder.md
Name: prv_trap_responder

Overview:
- Privilege-side counterpart of the pipeline hazard unit's exception/interrupt notification interface.
- Receives the prioritisable exception flags, EPC, bad address, ret and wfi from the pipeline.
- Decides whether a trap or return commits, then updates mepc/mcause/mtval/mstatus.MIE/MPIE.
- Drives the PC redirect (insert_pc, priv_pc) and the interrupt request (intr) back to the hazard unit.

Parameters:
XLEN, 32, data/address width (only 32 supported)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_l, mal_s, fault_l, fault_s  in  1 each  exception flags from pipeline
wb_enable  in  1  pipeline can commit this cycle (interrupt acceptance gate)
ret  in  1  mret executing
wfi  in  1  wfi executing
epc  in  XLEN  PC of trapping/interrupted insn
badaddr  in  XLEN  faulting address
ints_pending  in  3  {meip, mtip, msip}
ints_enabled  in  3  mie bits, same order
mtvec  in  XLEN  trap vector; [1:0] = mode
csr_wen  in  1  CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  combinational read of csr_addr, 0 if unmapped
intr  out  1  interrupt request to hazard unit
insert_pc  out  1  one-cycle redirect strobe
priv_pc  out  XLEN  redirect target, valid with insert_pc
wfi_sleep  out  1  core sleeping; hazard unit treats it as halt
mie_out  out  1  current mstatus.MIE

Behaviour:
- Reset: state IDLE; mepc, mcause, mtval = 0; MIE = 0; MPIE = 0; insert_pc = 0; priv_pc = 0; wfi_sleep = 0.
- States: IDLE, REDIRECT, SLEEP.
- Combinational signals:
  - any_exc = OR of the nine flags.
  - int_vec = ints_pending & ints_enabled.
  - intr = (state == IDLE) & MIE & |int_vec & ~any_exc.
- IDLE, checked in this order:
  - any_exc: commit exception.
  - intr & wb_enable: commit interrupt.
  - ret: commit return.
  - wfi: go to SLEEP.
  - Otherwise stay in IDLE.
- Commit exception or interrupt, at the clock edge:
  - mepc <= {epc[31:1], 0}; mcause <= cause.
  - mtval <= badaddr for insn/load/store fault or misaligned; otherwise 0.
  - MPIE <= MIE; MIE <= 0.
  - priv_pc <= trap target; insert_pc <= 1; state -> REDIRECT.
- Commit return, at the clock edge:
  - MIE <= MPIE; MPIE <= 1.
  - priv_pc <= mepc; insert_pc <= 1; state -> REDIRECT.
- Latency: event seen in cycle N, insert_pc high in cycle N+1 only.
- REDIRECT:
  - insert_pc deasserts next cycle; state -> IDLE.
  - Every event (exception, ret, wfi, intr) is ignored in this state, because the pipeline is flushing.
- SLEEP:
  - wfi_sleep = 1 (registered).
  - Exit to IDLE when |int_vec, regardless of MIE; wfi_sleep drops the same edge.
  - If the wake condition already holds on wfi entry, spend one cycle in SLEEP, then return to IDLE.
- Exception priority, mcause[31] = 0:
  - fault_insn 1 > mal_insn 0 > illegal 2 > breakpoint 3 > env 11 > mal_l 4 > mal_s 6 > fault_l 5 > fault_s 7.
- Interrupt priority, mcause[31] = 1:
  - meip 11 > msip 3 > mtip 7.
- Trap target: {mtvec[31:2], 2'b00} (direct).
- CSR map:
  - 0x300 mstatus: bit 3 MIE, bit 7 MPIE, bits 12:11 read 2'b11, all other bits read 0 and ignore writes.
  - 0x341 mepc: bit 0 forced 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - All fields are written whole-word.
- Simultaneous events:
  - A trap or return commit overrides a CSR write to the same register in the same cycle.
  - An exception takes precedence over ret and over intr.
- Reset mid-REDIRECT or mid-SLEEP: next cycle state IDLE, all outputs at reset values.

Optional Feature:
VECTORED_MTVEC_EN
- Defined: when mtvec[1:0] == 2'b01, the interrupt target is {mtvec[31:2], 2'b00} + 4*cause_code; exceptions still go to the base.
- Not defined: mode bits are ignored and every trap goes to the base.

Test Plan:
1. Illegal insn: mtvec = 0x80000100, illegal_insn = 1, epc = 0x2004 -> next cycle insert_pc = 1, priv_pc = 0x80000100; mcause = 2; mepc = 0x2004; mtval = 0; MIE 1->0, MPIE = 1.
2. Priority: fault_l and mal_insn together, badaddr = 0x3003 -> mcause = 0, mtval = 0x3003.
3. Interrupts: MIE = 1, ints_enabled = 3'b111, ints_pending = 3'b011, wb_enable = 0 for 3 cycles then 1 -> intr high throughout, single commit, mcause = 0x80000003; with VECTORED_MTVEC_EN and mtvec = 0x1001, priv_pc = 0x100C.
4. Return: after test 1, ret = 1 -> priv_pc = 0x2004; MIE = 1, MPIE = 1; a ret asserted during REDIRECT is ignored (no second insert_pc).
5. Sleep: wfi = 1 with MIE = 0 -> wfi_sleep = 1; assert mtip with mie.mtie = 1 after 5 cycles -> wfi_sleep = 0 next edge, no trap taken.
6. CSR and reset: CSR write mstatus = 0xFFFFFFFF -> read-back 0x00001888. RST in REDIRECT -> state IDLE; insert_pc, mepc, mcause, MIE all 0.
